// File: rtl/bsg_slot_scheduler_rr.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_slot_scheduler_rr
//  Purpose  : Round-robin time-slot arbiter; each grant lasts at most
//             slot_cycles_p enabled cycles, ending early on release/drop.
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_slot_scheduler_rr #(
    parameter  int els_p         = 4,
    parameter  int slot_cycles_p = 8,
    localparam int id_width_lp   = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cnt_width_lp  = (slot_cycles_p > 1) ? $clog2(slot_cycles_p) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    en_i,
    input  logic [els_p-1:0]        reqs_i,
    input  logic                    release_i,
    output logic [els_p-1:0]        grants_o,
    output logic [id_width_lp-1:0]  slot_id_o,
    output logic [cnt_width_lp-1:0] slot_count_o,
    output logic                    slot_last_o,
    output logic                    busy_o
);

    localparam logic [cnt_width_lp-1:0] c_last_count = cnt_width_lp'(slot_cycles_p - 1);
    localparam logic [els_p-1:0]        c_one        = {{(els_p-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [els_p-1:0]        r_grants;
    logic [els_p-1:0]        w_grants_next;
    logic [id_width_lp-1:0]  r_slot_id;
    logic [id_width_lp-1:0]  w_slot_id_next;
    logic [cnt_width_lp-1:0] r_slot_count;
    logic [cnt_width_lp-1:0] w_slot_count_next;
    // Set by reset so the very first search starts at requester 0.
    logic                    r_fresh;
    logic                    w_fresh_next;

    logic [els_p-1:0]        w_owner_oh;
    logic [els_p-1:0]        w_elig;
    logic [els_p-1:0]        w_pick_oh;
    logic [id_width_lp-1:0]  w_pick;
    logic [id_width_lp-1:0]  w_cand;
    logic                    w_found;
    logic                    w_at_last;
    logic                    w_slot_end;
    int                      w_start;

    assign w_owner_oh = c_one << r_slot_id;
    assign w_pick_oh  = c_one << w_pick;
    assign w_at_last  = (r_slot_count == c_last_count);
    assign w_slot_end = release_i | ~reqs_i[r_slot_id] | w_at_last;

    // Scan from the start point outward; the owner naturally lands last
    // because the search begins one past it.
    always_comb begin
        w_start = (r_state == ST_IDLE && r_fresh) ? 0 : ((int'(r_slot_id) + 1) % els_p);
        w_elig  = (r_state == ST_GRANT && release_i) ? (reqs_i & ~w_owner_oh) : reqs_i;
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int i = els_p - 1; i >= 0; i--) begin
            w_cand = id_width_lp'((w_start + i) % els_p);
            if (w_elig[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_grants_next     = r_grants;
        w_slot_id_next    = r_slot_id;
        w_slot_count_next = r_slot_count;
        w_fresh_next      = r_fresh;
        if (en_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        w_state_next      = ST_GRANT;
                        w_grants_next     = w_pick_oh;
                        w_slot_id_next    = w_pick;
                        w_slot_count_next = '0;
                        w_fresh_next      = 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (!w_slot_end) begin
                        w_slot_count_next = r_slot_count + cnt_width_lp'(1);
                    end else if (w_found) begin
                        w_grants_next     = w_pick_oh;
                        w_slot_id_next    = w_pick;
                        w_slot_count_next = '0;
                    end else begin
                        w_state_next      = ST_IDLE;
                        w_grants_next     = '0;
                        w_slot_count_next = '0;
                    end
                end
                default: begin
                    w_state_next  = ST_IDLE;
                    w_grants_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= ST_IDLE;
            r_grants     <= '0;
            r_slot_id    <= '0;
            r_slot_count <= '0;
            r_fresh      <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_grants     <= w_grants_next;
            r_slot_id    <= w_slot_id_next;
            r_slot_count <= w_slot_count_next;
            r_fresh      <= w_fresh_next;
        end
    end

    assign grants_o     = r_grants;
    assign slot_id_o    = r_slot_id;
    assign slot_count_o = r_slot_count;
    assign busy_o       = (r_state == ST_GRANT);
    assign slot_last_o  = (r_state == ST_GRANT) && w_at_last;

endmodule
`default_nettype wire

// File: doc/bsg_slot_scheduler_rr.md
Name: bsg_slot_scheduler_rr

Overview:
- Time-slot arbiter that shares one resource among els_p requesters.
- Each grant lasts at most slot_cycles_p enabled cycles, counted by an internal wrap-at-max slot counter.
- A grant also ends early on release or request drop; ownership then passes round-robin.
- Sits between requester front-ends and a shared port (memory bank, link, DMA engine) that needs bounded-latency fair access.

Parameters:
- els_p, 4, number of requesters; must be >= 2.
- slot_cycles_p, 8, maximum enabled cycles per grant; must be >= 1.
- id_width_lp, `BSG_SAFE_CLOG2(els_p), width of slot_id_o; derived.
- cnt_width_lp, `BSG_WIDTH(slot_cycles_p-1), width of slot_count_o; derived.

Ports:
- clk_i, in, 1, clock; all state updates on posedge.
- reset_n_i, in, 1, reset; one clock; reset is asynchronous and active-low.
- en_i, in, 1, global advance enable; low freezes all state.
- reqs_i, in, els_p, per-requester request level; held high while access is wanted.
- release_i, in, 1, current owner finished; ends the slot at this edge.
- grants_o, out, els_p, registered one-hot grant; all-zero when idle.
- slot_id_o, out, id_width_lp, index of the current/last owner.
- slot_count_o, out, cnt_width_lp, enabled cycles elapsed in the current slot (0-based).
- slot_last_o, out, 1, high when granted and slot_count_o == slot_cycles_p-1; slot ends on the next en_i.
- busy_o, out, 1, high in GRANT state.

Behaviour:
- States are IDLE and GRANT.
- Reset (async assert, any time): state=IDLE, grants_o=0, slot_id_o=0, slot_count_o=0, slot_last_o=0, busy_o=0.
  - The rr pointer is set so the first search starts at requester 0.
  - Reset mid-slot drops the grant immediately, without waiting for a clock edge.
- en_i=0: no state, pointer, or counter change; outputs hold; request and release inputs are ignored.
- IDLE, en_i=1, any reqs_i bit set:
  - Pick the lowest index >= (slot_id_o+1) mod els_p, wrapping around.
  - Next edge: GRANT, grants_o one-hot at the pick, slot_id_o=pick, slot_count_o=0.
  - Latency from request to grant is 1 cycle.
  - Exception: from reset the search starts at 0.
- GRANT, en_i=1: the slot ends at this edge if any of the following holds:
  - release_i=1;
  - reqs_i[slot_id_o]=0;
  - slot_count_o == slot_cycles_p-1.
- If the slot does not end: slot_count_o increments by 1. It never exceeds slot_cycles_p-1.
- On slot end:
  - Search rr starting at slot_id_o+1. The current owner is eligible only last, and only if its request is still high and it did not release.
  - If a requester is found: grant it at the same edge with slot_count_o=0. There is no idle bubble.
  - If none is found: go to IDLE, grants_o=0, slot_count_o=0, slot_id_o holds.
- slot_cycles_p=1: every grant lasts exactly one enabled cycle; slot_last_o is high throughout GRANT.
- Simultaneous release_i and count at max: a single slot end, with no double advance.
- release_i in IDLE: ignored.
- reqs_i bits for non-owners may change at any time. They are sampled only at slot-end or IDLE arbitration edges.
- grants_o, slot_id_o and slot_count_o are pure flops.
  - slot_last_o and busy_o are combinational from flops only, with no input-to-output path.
- Grant is always one-hot or zero. busy_o == |grants_o.

Test Plan (els_p=4, slot_cycles_p=3):
- Reset, then reqs_i=0b0110 held, en_i=1:
  - grants_o=0b0010 at cycle 1, with slot_count_o 0,1,2.
  - slot_last_o high at count 2.
  - Then 0b0100 for 3 cycles, then 0b0010 again; no idle cycles between slots.
- reqs_i=0b0001 alone, held high: grants_o stays 0b0001 continuously; slot_count_o cycles 0,1,2,0,...; busy_o never drops.
- Owner 2 granted, release_i pulsed at count 0 with reqs_i=0b1100: grant moves to 0b1000 next cycle with count 0.
- Owner 3 granted, en_i low for 5 cycles mid-slot (count=1): all outputs frozen; after en_i returns, count goes 2, then the slot ends.
- Owner 1 at count 1: reset_n_i asserted low between clock edges → grants_o=0 immediately, before the next edge.
  - Release reset with reqs_i=0b1010 → first grant is 0b0010.
- Owner 0 drops reqs_i[0] at count 1 with no other requests: IDLE next cycle, grants_o=0, slot_id_o stays 0.
  - A later reqs_i=0b0001 regrants 0 after 1 cycle.
